// File: rtl/sar_search_ctrl_pkg.sv
// sar_search_ctrl_pkg: shared state encoding, default width and flag check for the SAR search controller.
package sar_search_ctrl_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic {IDLE = 1'b0, TEST = 1'b1} state_t;
  function automatic logic one_hot3(input logic a, input logic b, input logic c);
    return (a ^ b ^ c) & ~(a & b & c);
  endfunction
endpackage

// File: rtl/sar_search_ctrl_if.sv
// sar_search_ctrl_if: start request, comparator loop and result signals of the SAR search controller.
interface sar_search_ctrl_if
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int SW = $clog2(WIDTH) + 1;
  logic start;
  logic [WIDTH-1:0] trial;
  logic alb;
  logic aeb;
  logic agb;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic err;
  logic [SW-1:0] steps;
  modport master(input start, alb, aeb, agb, output trial, busy, done, result, err, steps);
  modport slave(output start, alb, aeb, agb, input trial, busy, done, result, err, steps);
endinterface

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: MSB-first successive-approximation search driving an external comparator, one bit per clock.
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst,
  sar_search_ctrl_if.master bus
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int SW = $clog2(WIDTH) + 1;
  state_t state, state_n;
  logic [WIDTH-1:0] trial, trial_n, kept, result, result_n;
  logic [IW-1:0] idx, idx_n;
  logic [SW-1:0] cnt, cnt_n, steps, steps_n;
  logic err, err_n, done, done_n, bad;
  assign bad = ~one_hot3(bus.alb, bus.aeb, bus.agb);
  assign kept = bus.alb ? trial & ~(WIDTH'(1) << idx) : trial;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      trial <= '0;
      idx <= '0;
      cnt <= '0;
      result <= '0;
      err <= 1'b0;
      steps <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      trial <= trial_n;
      idx <= idx_n;
      cnt <= cnt_n;
      result <= result_n;
      err <= err_n;
      steps <= steps_n;
      done <= done_n;
    end
  end
  // a search ends on a bad flag set, an exact match, or after resolving bit 0
  always_comb begin
    state_n = state;
    trial_n = trial;
    idx_n = idx;
    cnt_n = cnt;
    result_n = result;
    err_n = err;
    steps_n = steps;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (bus.start) begin
        state_n = TEST;
        trial_n = WIDTH'(1) << (WIDTH - 1);
        idx_n = IW'(WIDTH - 1);
        cnt_n = SW'(1);
      end
    end else if (bad || bus.aeb || idx == '0) begin
      state_n = IDLE;
      trial_n = '0;
      done_n = 1'b1;
      steps_n = cnt;
      err_n = bad;
      result_n = bad ? '0 : bus.aeb ? trial : kept;
    end else begin
      trial_n = kept | (WIDTH'(1) << (idx - IW'(1)));
      idx_n = idx - IW'(1);
      cnt_n = cnt + SW'(1);
    end
  end
  assign bus.trial = trial;
  assign bus.busy = state == TEST;
  assign bus.done = done;
  assign bus.result = result;
  assign bus.err = err;
  assign bus.steps = steps;
endmodule

// File: doc/sar_search_ctrl.md
SAR_SEARCH_CTRL -- requirements
Module: sar_search_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, width of the search word and comparator operands.
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request a new search; sampled only in IDLE.
REQ-005 Port: trial  output  WIDTH  candidate value driven to the external comparator's b operand.
REQ-006 Port: alb / aeb / agb  input  1 each  comparator result for unknown a versus trial.
REQ-007 Port: busy  output  1  high while a search is in progress.
REQ-008 Port: done  output  1  one-cycle pulse marking search completion.
REQ-009 Port: result  output  WIDTH  recovered value of a; valid while done is high and held until the next accepted start.
REQ-010 Port: err  output  1  comparator inconsistency flag; updated together with done.
REQ-011 Port: steps  output  clog2(WIDTH)+1  number of compare cycles used; updated together with done.

Function
REQ-012 Algorithm: successive-approximation binary search, MSB first; one bit is resolved per clock.
REQ-013 States: IDLE and TEST only.
REQ-014 IDLE to TEST: start=1 in IDLE loads trial=1<<(WIDTH-1), index=WIDTH-1 and step count=1.
REQ-015 Ignored start: start is ignored in TEST, with no restart and no queuing.
REQ-016 Sampling rule: in TEST, alb/aeb/agb are sampled at every rising edge; the comparator is combinational on trial.
REQ-017 Invalid compare: if the flags are not exactly one-hot, the block sets err=1, result=0, pulses done and returns to IDLE.
REQ-018 Early exit: aeb=1 sets result=trial, err=0, pulses done and returns to IDLE.
REQ-019 alb=1: current bit index is cleared in trial.
REQ-020 agb=1: current bit is kept.
REQ-021 Final bit (index=0, not aeb): result takes the updated trial, done pulses and the state returns to IDLE.
REQ-022 Otherwise: bit index-1 is set in trial, index is decremented and the step count is incremented.
REQ-023 Latency: done goes high on the cycle after the deciding sample; worst case WIDTH compare cycles plus 1.
REQ-024 busy: busy=1 exactly while in TEST.
REQ-025 done: done is registered, 1 cycle wide, and asserted while the state is already IDLE.
REQ-026 Back-to-back start: start high during the done cycle is accepted, so back-to-back searches are allowed.
REQ-027 IDLE trial: trial=0 while in IDLE.
REQ-028 Output stability: result, err and steps change only on done.

Reset
REQ-029 Reset values: rst=1 immediately forces state=IDLE, trial=0, busy=0, done=0, result=0, err=0, steps=0.
REQ-030 Reset mid-search: reset during TEST aborts the search with no done pulse; a fresh start is required after rst falls.
REQ-031 Release: the first start is accepted on the first rising edge with rst low.

Structure
REQ-032 Shared package contents: state encoding constants (IDLE, TEST) and the default WIDTH.
REQ-033 Sub-module: none required; a testbench-only comparator model named comparator_model (WIDTH-parameterised a/b to alb/aeb/agb) closes the loop.
REQ-034 Block contents: a single FSM with trial, index and step-count registers; no combinational path from inputs to outputs.

Verification
REQ-035 Midpoint: WIDTH=4, a=8, start pulse -> aeb on the first compare; done 1 cycle later with result=8, steps=1, err=0.
REQ-036 Minimum: a=0 -> trials 8,4,2,1, all alb; result=0, steps=4, done at cycle 5 after start.
REQ-037 Mixed path: a=11 -> trials 8(agb),12(alb),10(agb),11(aeb); result=11, steps=4.
REQ-038 Fault injection: force alb=agb=1 on the second compare -> done with err=1, result=0, steps=2; next search with a=5 gives result=5, err=0.
REQ-039 Start handling: start held high through an a=3 search -> mid-search start ignored; start in the done cycle launches a second search with trial=8 next cycle.
REQ-040 Reset mid-search: rst pulse at cycle 2 of an a=13 search -> outputs reset immediately, no done; a following a=13 search gives result=13.
